// File: rtl/nv_ram_rws_mask_init.sv
// Two-port masked-write RAM with post-reset clear sweep,
// selectable read-during-write policy and optional output flop.
module nv_ram_rws_mask_init #(
    parameter int DEPTH   = 128,
    parameter int AW      = 7,
    parameter int WIDTH   = 256,
    parameter int MASK_W  = 32,
    parameter int OUT_REG = 0,
    parameter int BYPASS  = 1
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rstn,
    input  logic [AW-1:0]     ra,
    input  logic              re,
    output logic [WIDTH-1:0]  dout,
    output logic              dout_vld,
    input  logic [AW-1:0]     wa,
    input  logic              we,
    input  logic [MASK_W-1:0] wmask,
    input  logic [WIDTH-1:0]  di,
    output logic              init_busy,
    input  logic [31:0]       pwrbus_ram_pd
);

    localparam int LW = WIDTH / MASK_W;
    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam logic [AW:0]   DEP  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [0:0]       state;
    logic [AW-1:0]    clr_cnt;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             wa_ok;
    logic             ra_ok;
    logic             wr_run;
    logic             rd_run;
    logic [AW-1:0]    wa_s;
    logic [AW-1:0]    ra_s;
    logic [WIDTH-1:0] old_w;
    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] rd_word;

    logic             mem_we;
    logic [AW-1:0]    mem_wa;
    logic [WIDTH-1:0] mem_wd;

    logic [WIDTH-1:0] rd_q;
    logic             vld1;

    logic unused_pd;
    assign unused_pd = ^pwrbus_ram_pd;

    assign wa_ok  = {1'b0, wa} < DEP;
    assign ra_ok  = {1'b0, ra} < DEP;
    assign wa_s   = wa_ok ? wa : '0;
    assign ra_s   = ra_ok ? ra : '0;
    assign wr_run = (state == RUN) && we && wa_ok;
    assign rd_run = (state == RUN) && re;
    assign old_w  = mem[wa_s];

    always_comb begin
        merged = old_w;
        for (int i = 0; i < MASK_W; i++) begin
            if (wmask[i]) begin
                merged[i*LW +: LW] = di[i*LW +: LW];
            end
        end
    end

    // Same-address collision: bypass forwards the merged word.
    always_comb begin
        rd_word = '0;
        if (ra_ok) begin
            if ((BYPASS != 0) && wr_run && (ra == wa)) begin
                rd_word = merged;
            end else begin
                rd_word = mem[ra_s];
            end
        end
    end

    always_comb begin
        mem_we = 1'b0;
        mem_wa = wa_s;
        mem_wd = merged;
        if (state == INIT) begin
            mem_we = nvdla_core_rstn;
            mem_wa = clr_cnt;
            mem_wd = '0;
        end else begin
            mem_we = wr_run;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state   <= INIT;
            clr_cnt <= '0;
        end else begin
            unique case (state)
                INIT: begin
                    if (clr_cnt == LAST) begin
                        state   <= RUN;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    assign init_busy = (state == INIT);

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            rd_q <= '0;
            vld1 <= 1'b0;
        end else begin
            vld1 <= rd_run;
            if (rd_run) begin
                rd_q <= rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [WIDTH-1:0] dout_q;
            logic             vld2;
            always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
                if (!nvdla_core_rstn) begin
                    dout_q <= '0;
                    vld2   <= 1'b0;
                end else begin
                    vld2 <= vld1;
                    if (vld1) begin
                        dout_q <= rd_q;
                    end
                end
            end
            assign dout     = dout_q;
            assign dout_vld = vld2;
        end else begin : g_noreg
            assign dout     = rd_q;
            assign dout_vld = vld1;
        end
    endgenerate

endmodule

// File: tb/tb_nv_ram_rws_mask_init.sv
// Bench: two RAM variants driven in lockstep, checked against
// an array-based reference model every cycle.
module tb_nv_ram_rws_mask_init;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [6:0]   ra = '0;
    logic         re = 1'b0;
    logic [6:0]   wa = '0;
    logic         we = 1'b0;
    logic [31:0]  wmask = '0;
    logic [255:0] di = '0;
    logic [31:0]  pd = '0;

    logic [255:0] dout_a;
    logic [255:0] dout_b;
    logic         vld_a;
    logic         vld_b;
    logic         busy_a;
    logic         busy_b;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nv_ram_rws_mask_init #(
        .DEPTH(128), .AW(7), .WIDTH(256), .MASK_W(32),
        .OUT_REG(0), .BYPASS(1)
    ) u_a (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
        .ra(ra), .re(re), .dout(dout_a), .dout_vld(vld_a),
        .wa(wa), .we(we), .wmask(wmask), .di(di),
        .init_busy(busy_a), .pwrbus_ram_pd(pd)
    );

    nv_ram_rws_mask_init #(
        .DEPTH(100), .AW(7), .WIDTH(256), .MASK_W(32),
        .OUT_REG(1), .BYPASS(0)
    ) u_b (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
        .ra(ra), .re(re), .dout(dout_b), .dout_vld(vld_b),
        .wa(wa), .we(we), .wmask(wmask), .di(di),
        .init_busy(busy_b), .pwrbus_ram_pd(pd)
    );

    // reference model, index 0 = variant A, 1 = variant B
    int           depth [2] = '{128, 100};
    int           lat   [2] = '{1, 2};
    bit           byp   [2] = '{1'b1, 1'b0};
    logic [255:0] mem   [2][128];
    int           init_left [2];
    bit           iss_v [2][2];
    logic [255:0] iss_d [2][2];
    logic [255:0] held  [2];

    task automatic check(input string tag,
                         input logic [255:0] got,
                         input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] merge(input logic [255:0] old,
                                           input logic [255:0] d,
                                           input logic [31:0] m);
        logic [255:0] r = old;
        for (int b = 0; b < 256; b++)
            if (m[b/8]) r[b] = d[b];
        return r;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            init_left[k] = depth[k];
            held[k] = '0;
            for (int s = 0; s < 2; s++) begin
                iss_v[k][s] = 1'b0;
                iss_d[k][s] = '0;
            end
        end
    endtask

    task automatic model_edge(input int k);
        bit           v = 1'b0;
        logic [255:0] r = '0;
        if (init_left[k] > 0) begin
            mem[k][depth[k] - init_left[k]] = '0;
            init_left[k]--;
        end else begin
            if (re) begin
                v = 1'b1;
                if (int'(ra) < depth[k]) begin
                    r = mem[k][ra];
                    if (byp[k] && we && wa == ra)
                        r = merge(r, di, wmask);
                end
            end
            if (we && int'(wa) < depth[k])
                mem[k][wa] = merge(mem[k][wa], di, wmask);
        end
        iss_v[k][1] = iss_v[k][0];
        iss_d[k][1] = iss_d[k][0];
        iss_v[k][0] = v;
        iss_d[k][0] = r;
        if (iss_v[k][lat[k]-1]) held[k] = iss_d[k][lat[k]-1];
    endtask

    task automatic check_outs();
        check("a.vld", 256'(vld_a), 256'(iss_v[0][0]));
        check("a.dout", dout_a, held[0]);
        check("a.busy", 256'(busy_a), 256'(init_left[0] > 0));
        check("b.vld", 256'(vld_b), 256'(iss_v[1][1]));
        check("b.dout", dout_b, held[1]);
        check("b.busy", 256'(busy_b), 256'(init_left[1] > 0));
    endtask

    task automatic step(input bit r_en, input logic [6:0] r_a,
                        input bit w_en, input logic [6:0] w_a,
                        input logic [31:0] m, input logic [255:0] d);
        re = r_en; ra = r_a; we = w_en; wa = w_a;
        wmask = m; di = d; pd = $urandom;
        model_edge(0);
        model_edge(1);
        @(negedge clk);
        check_outs();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        model_reset();
        check_outs();
        check("rst.dout_a", dout_a, '0);
        check("rst.vld_b", 256'(vld_b), '0);
        @(negedge clk);
        rstn = 1'b1;
        check_outs();
    endtask

    function automatic logic [6:0] rnd_addr();
        if ($urandom_range(0, 3) == 0)
            return 7'($urandom_range(95, 127));
        return 7'($urandom_range(0, 12));
    endfunction

    task automatic rnd_step();
        logic [6:0]  a_r = rnd_addr();
        logic [6:0]  a_w = ($urandom_range(0, 3) == 0) ? a_r : rnd_addr();
        logic [31:0] m;
        case ($urandom_range(0, 3))
            0: m = '1;
            1: m = '0;
            default: m = $urandom;
        endcase
        step(1'($urandom), a_r, 1'($urandom), a_w, m, rnd256());
    endtask

    initial begin
        logic [255:0] p11;
        logic [255:0] p22;
        logic [255:0] pa5;
        logic [255:0] exp_m;
        int busy_cnt;
        p11 = {32{8'h11}};
        p22 = {32{8'h22}};
        pa5 = {32{8'hA5}};

        do_reset();
        busy_cnt = busy_a ? 1 : 0;
        for (int i = 0; i < 128; i++) begin
            step(1'b1, 7'd5, 1'b1, 7'($urandom_range(0, 127)),
                 '1, rnd256());
            if (busy_a) busy_cnt++;
        end
        check("busy_len", 256'(busy_cnt), 256'(128));
        check("init.vld_a", 256'(vld_a), '0);

        step(1'b1, 7'd5, 1'b0, 7'd0, '0, '0);
        check("first_rd.vld", 256'(vld_a), 256'(1));
        check("first_rd.dout", dout_a, '0);

        step(1'b0, 7'd0, 1'b1, 7'd3, '1, pa5);
        step(1'b0, 7'd0, 1'b1, 7'd3, 32'h1, '1);
        step(1'b1, 7'd3, 1'b0, 7'd0, '0, '0);
        exp_m = {pa5[255:8], 8'hFF};
        check("mask.a", dout_a, exp_m);
        step(1'b0, 7'd0, 1'b0, 7'd0, '0, '0);
        check("mask.b", dout_b, exp_m);

        step(1'b0, 7'd0, 1'b1, 7'd10, '1, p11);
        step(1'b1, 7'd10, 1'b1, 7'd10, '1, p22);
        check("byp.a", dout_a, p22);
        step(1'b1, 7'd10, 1'b0, 7'd0, '0, '0);
        check("byp.b_old", dout_b, p11);
        check("reread.a", dout_a, p22);
        step(1'b0, 7'd0, 1'b0, 7'd0, '0, '0);
        check("reread.b", dout_b, p22);

        step(1'b1, 7'd0, 1'b0, 7'd0, '0, '0);
        step(1'b1, 7'd1, 1'b0, 7'd0, '0, '0);
        step(1'b1, 7'd2, 1'b0, 7'd0, '0, '0);
        step(1'b0, 7'd0, 1'b0, 7'd0, '0, '0);
        step(1'b0, 7'd0, 1'b0, 7'd0, '0, '0);
        check("oreg.hold_vld", 256'(vld_b), '0);

        step(1'b0, 7'd0, 1'b1, 7'd120, '1, 256'h1);
        step(1'b1, 7'd120, 1'b0, 7'd0, '0, '0);
        step(1'b1, 7'd99, 1'b0, 7'd0, '0, '0);
        check("oob.b", dout_b, '0);
        step(1'b1, 7'd0, 1'b0, 7'd0, '0, '0);

        for (int i = 0; i < 1500; i++) rnd_step();

        step(1'b1, 7'd3, 1'b1, 7'd4, '1, rnd256());
        do_reset();
        for (int i = 0; i < 130; i++)
            step(1'($urandom), rnd_addr(), 1'b0, 7'd0, '0, '0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, rnd_addr(), 1'b0, 7'd0, '0, '0);
            check("post_rst.a", dout_a, '0);
        end

        for (int i = 0; i < 1000; i++) rnd_step();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/nv_ram_rws_mask_init.md
Name: nv_ram_rws_mask_init

Overview:
- Parametrised two-port RAM: one write port, one read port, separate addresses, single clock. It is the next generation of the fixed-size rws RAM family.
- Adds per-lane write masking and a selectable read-during-write policy.
- Adds an optional output pipeline register with a matching valid strobe.
- Adds a hardware clear sequence after reset, so datapath buffers never read X/stale contents.

Parameters:
- DEPTH, 128, number of words; any value 2..4096, need not be a power of two.
- AW, 7, address width; must satisfy 2^AW >= DEPTH.
- WIDTH, 256, data word width in bits.
- MASK_W, 32, number of write-mask lanes; WIDTH must be divisible by MASK_W; lane width LW = WIDTH/MASK_W.
- OUT_REG, 0, 0 = read latency 1; 1 = extra output flop, read latency 2.
- BYPASS, 1, read-during-write to the same address: 1 = new (merged) data, 0 = old data.

Ports:
- nvdla_core_clk  input  1  the single clock; all state on the rising edge.
- nvdla_core_rstn  input  1  reset, asynchronous assert, active-low.
- ra  input  AW  read address.
- re  input  1  read enable.
- dout  output  WIDTH  read data.
- dout_vld  output  1  one-cycle strobe: dout carries a new read result.
- wa  input  AW  write address.
- we  input  1  write enable.
- wmask  input  MASK_W  lane enables; bit i writes di[i*LW +: LW].
- di  input  WIDTH  write data.
- init_busy  output  1  high while the clear sequence runs.
- pwrbus_ram_pd  input  32  power-bus control; functionally ignored.

Behaviour:
- Reset is asynchronous, active-low (nvdla_core_rstn = 0). While held:
  - FSM = INIT, clr_cnt = 0, init_busy = 1.
  - dout_vld = 0, dout = 0, internal read-data and pipeline registers = 0.
  - Memory contents are not reset directly.
- FSM has two states, INIT and RUN.
- INIT:
  - Each cycle writes all-zero to M[clr_cnt], then clr_cnt increments.
  - When clr_cnt == DEPTH-1, that word is written and FSM moves to RUN on the same edge.
  - INIT therefore lasts exactly DEPTH cycles after reset deassertion; init_busy falls with the entry to RUN.
  - re and we are ignored in INIT: no write, no read, dout_vld stays 0.
- RUN, write: when we = 1 and wa < DEPTH, lanes with wmask[i] = 1 are updated at the edge; other lanes keep their value.
  - wmask = 0 is a legal no-op.
  - wa >= DEPTH: write is dropped.
- RUN, read: when re = 1, the read-data register captures M[ra] at the edge; ra >= DEPTH captures 0.
  - OUT_REG = 0: dout = read-data register; dout_vld = 1 the cycle after re.
  - OUT_REG = 1: a second flop stage holds dout; dout_vld = 1 two cycles after re. The valid strobe is pipelined alongside the data.
  - Back-to-back reads give one result per cycle.
  - When re = 0, dout holds its last value and dout_vld = 0.
  - Later writes never alter a result already captured.
- Same-cycle re and we with ra == wa (< DEPTH):
  - BYPASS = 1: captured value = old word with masked lanes replaced by di.
  - BYPASS = 0: captured value = old word; the memory is still updated.
- Reset asserted mid-operation: in-flight reads are discarded, dout and dout_vld go to 0, and the full INIT sweep is re-executed.
- pwrbus_ram_pd has no functional effect in this model.

Test Plan:
- Reset, then release; hold re = 1, ra = 5 throughout INIT -> init_busy = 1 for exactly 128 cycles and dout_vld stays 0; first RUN read of ra = 5 returns 0 with dout_vld one cycle later (OUT_REG = 0).
- After init, write wa = 3, di = all-0xA5 bytes, wmask = all-ones; next cycle write wa = 3, di = all-0xFF, wmask = 0x0000_0001; then read ra = 3 -> dout byte 0 = 0xFF, bytes 1..31 = 0xA5.
- Same-cycle we/re at address 10: prior content 0x11 pattern, di 0x22 pattern, full mask -> BYPASS = 1 returns the 0x22 pattern; BYPASS = 0 returns the 0x11 pattern; in both cases a re-read of address 10 returns the 0x22 pattern.
- OUT_REG = 1: reads of ra = 0, 1, 2 on consecutive cycles -> dout_vld high on cycles +2, +3, +4 with the matching data; dout holds the address-2 data afterwards.
- DEPTH = 100, AW = 7: write wa = 120 with data 0x1 -> no memory change; read ra = 120 returns 0; reads of ra = 99 and ra = 0 are unaffected.
- Assert nvdla_core_rstn low for 1 cycle mid-stream, with a read in flight and memory nonzero -> dout_vld drops immediately and dout = 0; init_busy = 1 for DEPTH cycles; all subsequent reads return 0.
